// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared constants and field helpers for the forwarding register file
//
// Purpose: default widths, forwarding channel layout {we, ready, waddr, wdata}
//          and pipeline source indices shared by regfile_fwd_sb and rf_fwd_mux.
package rf_pkg;

  localparam int AW_DEF = 5;
  localparam int DW_DEF = 32;

  // Forwarding source indices; lower index = younger producer.
  localparam int SRC_EX  = 0;
  localparam int SRC_MEM = 1;
  localparam int SRC_WB  = 2;

  localparam int FWD_DATA_LO = 0;

  function automatic int srcw(input int aw, input int dw);
    return 2 + aw + dw;
  endfunction

  function automatic int fwd_we(input int aw, input int dw);
    return aw + dw + 1;
  endfunction

  function automatic int fwd_rdy(input int aw, input int dw);
    return aw + dw;
  endfunction

  function automatic int fwd_addr_hi(input int aw, input int dw);
    return aw + dw - 1;
  endfunction

  function automatic int fwd_addr_lo(input int dw);
    return dw;
  endfunction

  function automatic int fwd_data_hi(input int dw);
    return dw - 1;
  endfunction

endpackage

// File: rtl/rf_fwd_mux.sv
// rtl/rf_fwd_mux.sv - one read port's operand selection with forwarding and stall
//
// Purpose: resolves a single read address against the zero register, the
//          forwarding channels (youngest first), the WB write-through and the
//          architectural array / busy bit.
// Ports:
//   a        in   AW         read address
//   fwd_bus  in   NSRC*SRCW  forwarding channels, channel k at [k*SRCW +: SRCW]
//   we/waddr/wdata in        WB commit port (write-through source)
//   arr_word in   DW         array[a]
//   busy_bit in   1          busy[a]
//   rdata_i  out  DW         selected operand
//   rstall_i out  1          operand not yet available
module rf_fwd_mux
  import rf_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int AW   = AW_DEF,
  parameter int NSRC = 3
) (
  input  logic [AW-1:0]                  a,
  input  logic [NSRC*srcw(AW, DW)-1:0]   fwd_bus,
  input  logic                           we,
  input  logic [AW-1:0]                  waddr,
  input  logic [DW-1:0]                  wdata,
  input  logic [DW-1:0]                  arr_word,
  input  logic                           busy_bit,
  output logic [DW-1:0]                  rdata_i,
  output logic                           rstall_i
);

  localparam int SRCW    = srcw(AW, DW);
  localparam int WE_B    = fwd_we(AW, DW);
  localparam int RDY_B   = fwd_rdy(AW, DW);
  localparam int ADDR_HI = fwd_addr_hi(AW, DW);
  localparam int ADDR_LO = fwd_addr_lo(DW);
  localparam int DATA_HI = fwd_data_hi(DW);

  logic [NSRC-1:0] ch_we;
  logic [NSRC-1:0] ch_rdy;
  logic [AW-1:0]   ch_addr [NSRC];
  logic [DW-1:0]   ch_data [NSRC];

  for (genvar k = 0; k < NSRC; k++) begin : g_ch
    assign ch_we[k]   = fwd_bus[k*SRCW + WE_B];
    assign ch_rdy[k]  = fwd_bus[k*SRCW + RDY_B];
    assign ch_addr[k] = fwd_bus[k*SRCW + ADDR_HI : k*SRCW + ADDR_LO];
    assign ch_data[k] = fwd_bus[k*SRCW + DATA_HI : k*SRCW + FWD_DATA_LO];
  end

  // Lowest-priority sources are applied first so later assignments win:
  // array/busy, then write-through, then channels oldest to youngest, then r0.
  always_comb begin
    rdata_i  = arr_word;
    rstall_i = busy_bit;
    if (we && (waddr == a)) begin
      rdata_i  = wdata;
      rstall_i = 1'b0;
    end
    for (int k = NSRC - 1; k >= 0; k--) begin
      if (ch_we[k] && (ch_addr[k] == a)) begin
        rdata_i  = ch_data[k];
        rstall_i = ~ch_rdy[k];
      end
    end
    if (a == '0) begin
      rdata_i  = '0;
      rstall_i = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_fwd_sb.sv
// rtl/regfile_fwd_sb.sv - register file with forwarding, write-through and busy scoreboard
//
// Purpose: NREG x DW architectural array with async reset, per-register busy
//          scoreboard for long-latency producers, and NRD zero-latency read
//          ports that forward from NSRC pipeline stages and stall on
//          operands that are not yet available.
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   raddr   in  NRD*AW   read addresses, port i at [i*AW +: AW]
//   rdata   out NRD*DW   read data, port i at [i*DW +: DW]
//   rstall  out NRD      per-port operand-not-available
//   fwd_bus in  NSRC*SRCW forwarding channels {we, ready, waddr, wdata}
//   we/waddr/wdata       WB commit port
//   iss_we/iss_waddr     long-latency op issue (sets busy)
//   busy    out NREG     scoreboard state
module regfile_fwd_sb
  import rf_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int AW   = AW_DEF,
  parameter int NRD  = 2,
  parameter int NSRC = 3
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NRD*AW-1:0]             raddr,
  output logic [NRD*DW-1:0]             rdata,
  output logic [NRD-1:0]                rstall,
  input  logic [NSRC*srcw(AW, DW)-1:0]  fwd_bus,
  input  logic                          we,
  input  logic [AW-1:0]                 waddr,
  input  logic [DW-1:0]                 wdata,
  input  logic                          iss_we,
  input  logic [AW-1:0]                 iss_waddr,
  output logic [2**AW-1:0]              busy
);

  localparam int NREG = 2**AW;

  logic [DW-1:0]   mem_q [NREG];
  logic [DW-1:0]   mem_d [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Set is applied after clear: an op issued this cycle is younger than the
  // one committing, so the register stays busy.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    if (we && (waddr != '0)) begin
      mem_d[waddr] = wdata;
    end
    if (we) begin
      busy_d[waddr] = 1'b0;
    end
    if (iss_we) begin
      busy_d[iss_waddr] = 1'b1;
    end
    mem_d[0]  = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_q  <= '{default: '0};
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] a;
    assign a = raddr[i*AW +: AW];

    rf_fwd_mux #(
      .DW   (DW),
      .AW   (AW),
      .NSRC (NSRC)
    ) u_mux (
      .a        (a),
      .fwd_bus  (fwd_bus),
      .we       (we),
      .waddr    (waddr),
      .wdata    (wdata),
      .arr_word (mem_q[a]),
      .busy_bit (busy_q[a]),
      .rdata_i  (rdata[i*DW +: DW]),
      .rstall_i (rstall[i])
    );
  end

endmodule

// File: tb/tb_regfile_fwd_sb.sv
// tb/tb_regfile_fwd_sb.sv - self-checking bench for regfile_fwd_sb
module tb_regfile_fwd_sb;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;
  localparam int NSRC = 3;
  localparam int SRCW = 2 + AW + DW;

  logic                  clk;
  logic                  resetn;
  logic [NRD*AW-1:0]     raddr;
  logic [NRD*DW-1:0]     rdata;
  logic [NRD-1:0]        rstall;
  logic [NSRC*SRCW-1:0]  fwd_bus;
  logic                  we;
  logic [AW-1:0]         waddr;
  logic [DW-1:0]         wdata;
  logic                  iss_we;
  logic [AW-1:0]         iss_waddr;
  logic [2**AW-1:0]      busy;

  int total = 0;
  int bad   = 0;

  regfile_fwd_sb #(.DW(DW), .AW(AW), .NRD(NRD), .NSRC(NSRC)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .raddr     (raddr),
    .rdata     (rdata),
    .rstall    (rstall),
    .fwd_bus   (fwd_bus),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .iss_we    (iss_we),
    .iss_waddr (iss_waddr),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0]   ra0;
    logic [AW-1:0]   ra1;
    logic [SRCW-1:0] ex;
    logic [SRCW-1:0] mem;
    logic [SRCW-1:0] wb;
    logic            we;
    logic [AW-1:0]   wa;
    logic [DW-1:0]   wd;
    logic            iw;
    logic [AW-1:0]   ia;
    logic [DW-1:0]   e0;
    logic            s0;
    logic            chk_d0;
    logic [DW-1:0]   e1;
    logic            s1;
  } vec_t;

  vec_t vt[9];

  function automatic logic [SRCW-1:0] ch(input logic w, input logic r,
                                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    return {w, r, a, d};
  endfunction

  function automatic vec_t mkv(
      input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
      input logic [SRCW-1:0] ex, input logic [SRCW-1:0] mem, input logic [SRCW-1:0] wb,
      input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
      input logic iw, input logic [AW-1:0] ia,
      input logic [DW-1:0] e0, input logic s0, input logic cd0,
      input logic [DW-1:0] e1, input logic s1);
    vec_t v;
    v.ra0 = ra0; v.ra1 = ra1; v.ex = ex; v.mem = mem; v.wb = wb;
    v.we = w; v.wa = wa; v.wd = wd; v.iw = iw; v.ia = ia;
    v.e0 = e0; v.s0 = s0; v.chk_d0 = cd0; v.e1 = e1; v.s1 = s1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    fwd_bus   = '0;
    we        = 1'b0;
    waddr     = '0;
    wdata     = '0;
    iss_we    = 1'b0;
    iss_waddr = '0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    raddr = {a1, a0};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [SRCW-1:0] off;
    off = '0;

    vt[0] = mkv(8, 5, ch(1,1,8,32'h11), ch(1,1,8,32'h22), off, 1, 8, 32'h33, 0, 0,
                32'h11, 0, 1, 32'h0, 0);
    vt[1] = mkv(8, 8, off, ch(1,1,8,32'h22), off, 1, 8, 32'h33, 0, 0,
                32'h22, 0, 1, 32'h22, 0);
    vt[2] = mkv(8, 8, off, off, off, 1, 8, 32'h33, 0, 0,
                32'h33, 0, 1, 32'h33, 0);
    vt[3] = mkv(8, 8, off, off, off, 0, 0, 32'h0, 0, 0,
                32'h33, 0, 1, 32'h33, 0);
    vt[4] = mkv(9, 9, ch(1,0,9,32'hABAB), ch(1,1,9,32'h44), off, 0, 0, 32'h0, 0, 0,
                32'h0, 1, 0, 32'hABAB, 1);
    vt[5] = mkv(9, 8, off, ch(1,1,9,32'h55), off, 0, 0, 32'h0, 0, 0,
                32'h55, 0, 1, 32'h33, 0);
    vt[6] = mkv(10, 9, off, off, ch(1,1,10,32'hAB), 0, 0, 32'h0, 0, 0,
                32'hAB, 0, 1, 32'h0, 0);
    vt[7] = mkv(0, 0, ch(1,1,0,32'hFFFF), ch(1,0,0,32'hFFFF), ch(1,1,0,32'hFFFF),
                1, 0, 32'hFFFF, 1, 0, 32'h0, 0, 1, 32'h0, 0);
    vt[8] = mkv(0, 8, off, off, off, 0, 0, 32'h0, 0, 0,
                32'h0, 0, 1, 32'h33, 0);

    resetn = 1'b0;
    idle_inputs();
    set_rd(5, 5);
    #2;
    chk("rst_busy", busy, 32'h0);
    chk("rst_rdata0", rdata[DW-1:0], 32'h0);
    chk("rst_rstall", {30'b0, rstall}, 32'h0);
    fwd_bus = {off, off, ch(1,1,5,32'h5A)};
    #1;
    chk("rst_fwd_rdata0", rdata[DW-1:0], 32'h5A);
    fwd_bus = '0;
    #2;
    resetn = 1'b1;
    step();

    we = 1'b1; waddr = 5; wdata = 32'hDEADBEEF;
    iss_we = 1'b1; iss_waddr = 7;
    step();
    idle_inputs();
    #1;
    chk("wr_r5", rdata[DW-1:0], 32'hDEADBEEF);
    chk("busy7_set", {31'b0, busy[7]}, 32'h1);
    #1;
    resetn = 1'b0;
    #1;
    chk("async_rst_r5", rdata[DW-1:0], 32'h0);
    chk("async_rst_busy", busy, 32'h0);
    resetn = 1'b1;
    step();

    for (int i = 0; i < 9; i++) begin
      set_rd(vt[i].ra0, vt[i].ra1);
      fwd_bus   = {vt[i].wb, vt[i].mem, vt[i].ex};
      we        = vt[i].we;
      waddr     = vt[i].wa;
      wdata     = vt[i].wd;
      iss_we    = vt[i].iw;
      iss_waddr = vt[i].ia;
      #1;
      if (vt[i].chk_d0) chk($sformatf("vec%0d_rdata0", i), rdata[DW-1:0], vt[i].e0);
      chk($sformatf("vec%0d_rstall0", i), {31'b0, rstall[0]}, {31'b0, vt[i].s0});
      chk($sformatf("vec%0d_rdata1", i), rdata[2*DW-1:DW], vt[i].e1);
      chk($sformatf("vec%0d_rstall1", i), {31'b0, rstall[1]}, {31'b0, vt[i].s1});
      step();
    end
    chk("busy0_zero", {31'b0, busy[0]}, 32'h0);
    chk("busy_all_zero", busy, 32'h0);

    idle_inputs();
    set_rd(12, 12);
    iss_we = 1'b1; iss_waddr = 12;
    step();
    iss_we = 1'b0;
    #1;
    chk("busy12_set", {31'b0, busy[12]}, 32'h1);
    for (int c = 0; c < 20; c++) begin
      chk($sformatf("busy12_stall_c%0d", c), {31'b0, rstall[0]}, 32'h1);
      step();
    end
    fwd_bus = {off, ch(1,1,12,32'h66), off};
    #1;
    chk("busy12_fwd_rdata", rdata[DW-1:0], 32'h66);
    chk("busy12_fwd_rstall", {31'b0, rstall[0]}, 32'h0);
    fwd_bus = '0;
    we = 1'b1; waddr = 12; wdata = 32'h99;
    #1;
    chk("busy12_wt_rdata", rdata[DW-1:0], 32'h99);
    chk("busy12_wt_rstall", {31'b0, rstall[0]}, 32'h0);
    step();
    idle_inputs();
    #1;
    chk("busy12_clear", {31'b0, busy[12]}, 32'h0);
    chk("r12_after", rdata[DW-1:0], 32'h99);
    chk("r12_after_rstall", {31'b0, rstall[0]}, 32'h0);

    set_rd(3, 3);
    iss_we = 1'b1; iss_waddr = 3;
    step();
    #1;
    chk("busy3_set", {31'b0, busy[3]}, 32'h1);
    we = 1'b1; waddr = 3; wdata = 32'h7;
    #1;
    chk("coll_wt_rdata", rdata[DW-1:0], 32'h7);
    chk("coll_wt_rstall", {31'b0, rstall[0]}, 32'h0);
    step();
    idle_inputs();
    #1;
    chk("coll_busy3", {31'b0, busy[3]}, 32'h1);
    chk("coll_rstall", {31'b0, rstall[0]}, 32'h1);
    chk("coll_array", rdata[DW-1:0], 32'h7);
    chk("coll_port1", rdata[2*DW-1:DW], 32'h7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
